// File: rtl/issue_scoreboard.sv
// Dual-issue hazard scheduler: per-GPR and HI/LO forwarding countdowns,
// intra-bundle dependency checks and the divider occupancy counter.
module issue_scoreboard #(
  parameter int unsigned LAT_ALU  = 0,
  parameter int unsigned LAT_LATE = 2,
  parameter int unsigned LAT_MULT = 1,
  parameter int unsigned DIV_CYC  = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        stall_in,
  input  logic [1:0]  valid,
  input  logic [19:0] src_addr,
  input  logic [3:0]  src_use,
  input  logic [9:0]  dst_addr,
  input  logic [1:0]  dst_we,
  input  logic [1:0]  dst_late,
  input  logic [1:0]  hilo_rd,
  input  logic [1:0]  hilo_wr,
  input  logic [1:0]  is_div,
  output logic [1:0]  issue,
  output logic        hilo_busy,
  output logic        div_start
);

  localparam logic [1:0] CNT_ALU  = 2'(LAT_ALU + 1);
  localparam logic [1:0] CNT_LATE = 2'(LAT_LATE + 1);
  localparam logic [1:0] CNT_MULT = 2'(LAT_MULT + 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYC);

  logic [1:0]  cnt_r      [32];
  logic [1:0]  cnt_nxt_s  [32];
  logic [1:0]  hl_cnt_r;
  logic [1:0]  hl_cnt_nxt_s;
  logic [5:0]  div_cnt_r;
  logic [5:0]  div_cnt_nxt_s;

  logic [4:0]  src_s [4];
  logic [4:0]  dst_s [2];
  logic [31:0] gpr_busy_s;
  logic        hl_haz_s;
  logic [1:0]  touch_hl_s;
  logic [1:0]  slot_clear_s;
  logic        dep_s;
  logic        ok0_s;
  logic        ok1_s;
  logic        hl_write_s;

  // Issue decision. A count of 1 means the producer sits in execute and its
  // result is already reachable through the bypass, so only counts above 1 stall.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      src_s[i] = src_addr[5*i +: 5];
    end
    dst_s[0] = dst_addr[4:0];
    dst_s[1] = dst_addr[9:5];

    gpr_busy_s[0] = 1'b0;
    for (int r = 1; r < 32; r++) begin
      gpr_busy_s[r] = (cnt_r[r] > 2'd1);
    end
    hl_haz_s = (hl_cnt_r > 2'd1) || (div_cnt_r != 6'd0);

    for (int k = 0; k < 2; k++) begin
      touch_hl_s[k]   = hilo_rd[k] || hilo_wr[k] || is_div[k];
      slot_clear_s[k] = !(src_use[2*k]   && gpr_busy_s[src_s[2*k]])
                     && !(src_use[2*k+1] && gpr_busy_s[src_s[2*k+1]])
                     && !(touch_hl_s[k]  && hl_haz_s);
    end

    dep_s = dst_we[0] && (dst_s[0] != 5'd0)
         && ((src_use[2] && (src_s[2] == dst_s[0])) ||
             (src_use[3] && (src_s[3] == dst_s[0])));

    ok0_s = valid[0] && !stall_in && !flush && slot_clear_s[0];
    ok1_s = ok0_s && valid[1] && slot_clear_s[1] && !dep_s
         && !(touch_hl_s[0] && touch_hl_s[1]) && !is_div[1];

    issue     = {ok1_s, ok0_s};
    div_start = ok0_s && is_div[0];
  end

  // Next-state of all countdowns; slot1 assignments come last so the younger writer wins.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      if (!stall_in && (cnt_r[r] != 2'd0)) begin
        cnt_nxt_s[r] = cnt_r[r] - 2'd1;
      end else begin
        cnt_nxt_s[r] = cnt_r[r];
      end
      for (int k = 0; k < 2; k++) begin
        if (issue[k] && dst_we[k] && (dst_s[k] == 5'(r))) begin
          cnt_nxt_s[r] = dst_late[k] ? CNT_LATE : CNT_ALU;
        end else begin
          cnt_nxt_s[r] = cnt_nxt_s[r];
        end
      end
    end
    cnt_nxt_s[0] = 2'd0;

    hl_write_s = (issue[0] && hilo_wr[0]) || (issue[1] && hilo_wr[1]);
    if (hl_write_s) begin
      hl_cnt_nxt_s = CNT_MULT;
    end else if (hl_cnt_r != 2'd0) begin
      hl_cnt_nxt_s = hl_cnt_r - 2'd1;
    end else begin
      hl_cnt_nxt_s = hl_cnt_r;
    end

    if (div_start) begin
      div_cnt_nxt_s = DIV_LOAD;
    end else if (div_cnt_r != 6'd0) begin
      div_cnt_nxt_s = div_cnt_r - 6'd1;
    end else begin
      div_cnt_nxt_s = div_cnt_r;
    end
  end

  // State registers; flush kills every in-flight producer including the divider.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < 32; r++) begin
        cnt_r[r] <= 2'd0;
      end
      hl_cnt_r  <= 2'd0;
      div_cnt_r <= 6'd0;
      hilo_busy <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < 32; r++) begin
        cnt_r[r] <= 2'd0;
      end
      hl_cnt_r  <= 2'd0;
      div_cnt_r <= 6'd0;
      hilo_busy <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
      end
      hl_cnt_r  <= hl_cnt_nxt_s;
      div_cnt_r <= div_cnt_nxt_s;
      hilo_busy <= (div_cnt_nxt_s != 6'd0);
    end
  end

endmodule
